scroll_hop: RTL and testbench

SCROLL_HOP -- requirements
Module: scroll_hop

---
 rtl/scroll_hop.sv | 144 ++++++++++++++
 tb/tb_scroll_hop.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/scroll_hop.sv
// Obstacle vertical scroller: a debounced push-button starts a hop of HOP_DIST pixels in HOP_STEP
// increments, one per frame. Define SCROLL_HOP_QUEUE_EN to remember one press made during a hop or cooldown.
module scroll_hop #(
  parameter int SCREEN_HEIGHT   = 480,
  parameter int HOP_DIST        = 30,
  parameter int HOP_STEP        = 5,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int COOL_FRAMES     = 2,
  parameter int Y_START         = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_btn,
  input  logic       frame_tick,
  output logic [9:0] y_pos,
  output logic       hopping,
  output logic [7:0] hop_count,
  output logic [1:0] state_dbg
);

  localparam int STEPS = HOP_DIST / HOP_STEP;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOP      = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  sync_q;
  logic        db_level;
  logic [3:0]  db_cnt;
  logic [3:0]  cool_cnt;
  logic [7:0]  step_cnt;
  logic        db_differs;
  logic        db_flip;
  logic        press;
  logic        take_queued;
  logic [10:0] y_sum;
  logic [9:0]  y_next;

  assign state_dbg = state;

  // The press pulse fires in the same clk as the frame sample that flips the debounced level high.
  assign db_differs = (sync_q[1] != db_level);
  assign db_flip    = frame_tick && db_differs && (db_cnt == 4'(DEBOUNCE_FRAMES - 1));
  assign press      = db_flip && sync_q[1];

  assign y_sum  = {1'b0, y_pos} + 11'(HOP_STEP);
  assign y_next = (y_sum >= 11'(SCREEN_HEIGHT)) ? 10'(y_sum - 11'(SCREEN_HEIGHT)) : y_sum[9:0];

`ifdef SCROLL_HOP_QUEUE_EN
  logic pending;
  // A press landing on the last cooldown tick counts as pending for that same tick.
  assign take_queued = pending || press;
`else
  assign take_queued = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= 2'b00;
      db_level <= 1'b0;
      db_cnt   <= 4'd0;
    end else begin
      sync_q <= {sync_q[0], move_btn};
      if (frame_tick) begin
        if (!db_differs) begin
          db_cnt <= 4'd0;
        end else if (db_flip) begin
          db_level <= ~db_level;
          db_cnt   <= 4'd0;
        end else begin
          db_cnt <= db_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      y_pos     <= 10'(Y_START);
      hopping   <= 1'b0;
      hop_count <= 8'd0;
      step_cnt  <= 8'd0;
      cool_cnt  <= 4'd0;
`ifdef SCROLL_HOP_QUEUE_EN
      pending   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (press) begin
            state    <= HOP;
            hopping  <= 1'b1;
            step_cnt <= 8'd0;
            if (hop_count != 8'hFF) hop_count <= hop_count + 8'd1;
          end
        end
        HOP: begin
`ifdef SCROLL_HOP_QUEUE_EN
          if (press) pending <= 1'b1;
`endif
          if (frame_tick) begin
            y_pos <= y_next;
            if (step_cnt == 8'(STEPS - 1)) begin
              state    <= COOLDOWN;
              hopping  <= 1'b0;
              cool_cnt <= 4'd0;
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end
        COOLDOWN: begin
`ifdef SCROLL_HOP_QUEUE_EN
          if (press) pending <= 1'b1;
`endif
          if (frame_tick) begin
            if (cool_cnt == 4'(COOL_FRAMES - 1)) begin
              cool_cnt <= 4'd0;
              if (take_queued) begin
                state    <= HOP;
                hopping  <= 1'b1;
                step_cnt <= 8'd0;
                if (hop_count != 8'hFF) hop_count <= hop_count + 8'd1;
`ifdef SCROLL_HOP_QUEUE_EN
                pending  <= 1'b0;
`endif
              end else begin
                state <= IDLE;
              end
            end else begin
              cool_cnt <= cool_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scroll_hop.sv
// Bench for scroll_hop: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a frame-level reference model.
module tb_scroll_hop;

  localparam int SCREEN_HEIGHT = 480;
  localparam int HOP_DIST      = 30;
  localparam int HOP_STEP      = 5;
  localparam int DEB           = 4;
  localparam int COOL          = 2;
  localparam int STEPS         = HOP_DIST / HOP_STEP;
  localparam int Y2_START      = 470;
`ifdef SCROLL_HOP_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] y_pos, y_pos2;
  logic       hopping, hopping2;
  logic [7:0] hop_count, hop_count2;
  logic [1:0] state_dbg, state_dbg2;

  int checks = 0;
  int failures = 0;

  scroll_hop u_dut (
    .clk(clk), .reset(reset), .move_btn(btn), .frame_tick(tick),
    .y_pos(y_pos), .hopping(hopping), .hop_count(hop_count), .state_dbg(state_dbg)
  );

  scroll_hop #(.Y_START(Y2_START)) u_dut_wrap (
    .clk(clk), .reset(reset), .move_btn(btn), .frame_tick(tick),
    .y_pos(y_pos2), .hopping(hopping2), .hop_count(hop_count2), .state_dbg(state_dbg2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: button history, consecutive-sample run length, hops/cooldown frames remaining.
  bit [1:0] m_sync = 2'b00;
  bit       m_db = 1'b0;
  int       m_run = 0;
  int       m_hops_left = 0;
  int       m_cool_left = 0;
  bit       m_pend = 1'b0;
  int       m_y = 0;
  int       m_y2 = Y2_START;
  int       m_count = 0;

  task automatic model_reset();
    m_sync = 2'b00; m_db = 1'b0; m_run = 0; m_hops_left = 0; m_cool_left = 0;
    m_pend = 1'b0; m_y = 0; m_y2 = Y2_START; m_count = 0;
  endtask

  task automatic start_hop();
    m_hops_left = STEPS;
    m_count = (m_count >= 255) ? 255 : m_count + 1;
  endtask

  task automatic model_step();
    bit press;
    press = 1'b0;
    if (tick) begin
      if (m_sync[1] != m_db) begin
        m_run++;
        if (m_run == DEB) begin
          m_db = !m_db;
          m_run = 0;
          press = m_db;
        end
      end else begin
        m_run = 0;
      end
    end
    if (m_hops_left == 0 && m_cool_left == 0) begin
      if (press) start_hop();
    end else if (m_hops_left > 0) begin
      if (press && QUEUE) m_pend = 1'b1;
      if (tick) begin
        m_y  = (m_y + HOP_STEP) % SCREEN_HEIGHT;
        m_y2 = (m_y2 + HOP_STEP) % SCREEN_HEIGHT;
        m_hops_left--;
        if (m_hops_left == 0) m_cool_left = COOL;
      end
    end else begin
      if (press && QUEUE) m_pend = 1'b1;
      if (tick) begin
        m_cool_left--;
        if (m_cool_left == 0 && m_pend) begin
          m_pend = 1'b0;
          start_hop();
        end
      end
    end
    m_sync = {m_sync[0], btn};
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(posedge clk) begin
    #2;
    check("y_pos", int'(y_pos), m_y);
    check("hopping", int'(hopping), (m_hops_left > 0) ? 1 : 0);
    check("hop_count", int'(hop_count), m_count);
    check("y_pos_wrap", int'(y_pos2), m_y2);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; btn = 1'b0; tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One frame: button level settles through the synchronizer, then a single tick samples it.
  task automatic one_frame(input logic b);
    @(negedge clk);
    btn = b; tick = 1'b0;
    repeat (2) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  int exp_y2 [10] = '{470, 470, 470, 470, 475, 0, 5, 10, 15, 20};

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_y_pos", int'(y_pos), 0);
    check("rst_hopping", int'(hopping), 0);
    check("rst_hop_count", int'(hop_count), 0);
    check("rst_y_pos_wrap", int'(y_pos2), 470);
    reset = 1'b1;

    // Held button: one hop, 0->30 in 5s; wrap instance 470 -> 475,0,...,20
    for (int f = 1; f <= 10; f++) begin
      one_frame(1'b1);
      check("held_y", int'(y_pos), (f >= 5) ? 5 * (f - 4) : 0);
      check("held_hopping", int'(hopping), (f >= 4 && f <= 9) ? 1 : 0);
      check("held_y_wrap", int'(y_pos2), exp_y2[f-1]);
    end
    for (int f = 0; f < 4; f++) one_frame(1'b1);
    check("held_count", int'(hop_count), 1);
    check("held_y_end", int'(y_pos), 30);

    // Three-frame glitch is filtered out
    do_reset();
    for (int f = 0; f < 3; f++) one_frame(1'b1);
    for (int f = 0; f < 6; f++) one_frame(1'b0);
    check("glitch_y", int'(y_pos), 0);
    check("glitch_count", int'(hop_count), 0);

    // Second press landing on the final cooldown tick
    do_reset();
    for (int f = 1; f <= 20; f++) one_frame((f <= 4 || f >= 9) ? 1'b1 : 1'b0);
    check("second_y", int'(y_pos), QUEUE ? 60 : 30);
    check("second_count", int'(hop_count), QUEUE ? 2 : 1);

    // Asynchronous reset mid-hop, then a fresh press is honoured
    do_reset();
    for (int f = 1; f <= 7; f++) one_frame((f <= 4) ? 1'b1 : 1'b0);
    check("mid_y_before", int'(y_pos), 15);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_y", int'(y_pos), 0);
    check("async_hopping", int'(hopping), 0);
    check("async_count", int'(hop_count), 0);
    @(negedge clk);
    reset = 1'b1;
    one_frame(1'b0);
    check("post_rst_y", int'(y_pos), 0);
    for (int f = 0; f < 4; f++) one_frame(1'b1);
    check("post_rst_hopping", int'(hopping), 1);
    check("post_rst_count", int'(hop_count), 1);
    for (int f = 0; f < 8; f++) one_frame(1'b0);
    check("post_rst_y_end", int'(y_pos), 30);

    // 260 hops: counter saturates, position keeps wrapping
    do_reset();
    for (int h = 0; h < 260; h++) begin
      for (int f = 0; f < 5; f++) one_frame(1'b1);
      for (int f = 0; f < 5; f++) one_frame(1'b0);
    end
    check("sat_count", int'(hop_count), 255);
    check("sat_y", int'(y_pos), 120);
    check("sat_y_wrap", int'(y_pos2), 110);

    // Randomized traffic: irregular ticks, slow button changes, rare resets
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) btn = ~btn;
      reset = ($urandom_range(0, 1999) != 0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
